// File: rtl/mpmc11_pkg.sv
// Shared types and sizing for the mpmc11 read-tag dispatch path.
// Port tags, FIFO depth and occupancy count type.
package mpmc11_pkg;
  localparam int PORTW = 4;
  localparam int DEPTH = 16;
  localparam int DATA_WIDTH = 256;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef logic [PORTW-1:0] port_t;
  typedef logic [PTRW-1:0] ptr_t;
  typedef logic [CNTW-1:0] count_t;
endpackage

// File: rtl/mpmc11_tag_fifo.sv
// Single-clock FIFO of port tags with async read at the read pointer.
// Flags come from the occupancy count, not from pointer compare.
module mpmc11_tag_fifo
  import mpmc11_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [PORTW-1:0] din,
  input  logic             pop,
  output logic [PORTW-1:0] dout,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);
  port_t mem [DEPTH];
  ptr_t wptr;
  ptr_t rptr;

  assign dout  = mem[rptr];
  assign full  = (count == count_t'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mpmc11_rd_tag_dispatch.sv
// Tags memory read commands with their port and pairs returning
// read data with the oldest tag, emitting a one-cycle rdy strobe.
module mpmc11_rd_tag_dispatch
  import mpmc11_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [PORTW-1:0] cmd_port,
  output logic             cmd_rdy,
  input  logic             rd_valid,
  input  logic [DW-1:0]    rd_data,
  output logic             rdy,
  output logic [PORTW-1:0] fifo_port,
  output logic [DW-1:0]    dat_o,
  output logic [CNTW-1:0]  count,
  output logic             ovf_err,
  output logic             unf_err
);
  logic  full;
  logic  empty;
  logic  push;
  logic  pop;
  port_t tag;

  // A pop frees a slot this cycle, so a full FIFO still takes a push.
  assign pop     = rd_valid & ~empty;
  assign push    = cmd_valid & (~full | pop);
  assign cmd_rdy = ~full;

  mpmc11_tag_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (cmd_port),
    .pop   (pop),
    .dout  (tag),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdy       <= 1'b0;
      fifo_port <= '0;
      dat_o     <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      rdy <= pop;
      if (pop) begin
        fifo_port <= tag;
        dat_o     <= rd_data;
      end
      if (cmd_valid && !push) ovf_err <= 1'b1;
      if (rd_valid && empty) unf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mpmc11_rd_tag_dispatch.sv
// Directed bench for mpmc11_rd_tag_dispatch with a tag-queue model
// and an expected-output scoreboard.
module tb_mpmc11_rd_tag_dispatch;
  import mpmc11_pkg::*;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cmd_valid;
  logic [PORTW-1:0] cmd_port;
  logic             cmd_rdy;
  logic             rd_valid;
  logic [255:0]     rd_data;
  logic             rdy;
  logic [PORTW-1:0] fifo_port;
  logic [255:0]     dat_o;
  logic [CNTW-1:0]  count;
  logic             ovf_err;
  logic             unf_err;

  typedef struct {
    logic [PORTW-1:0] port;
    logic [255:0]     data;
  } beat_t;

  logic [PORTW-1:0] tag_q [$];
  beat_t            exp_q [$];
  logic [PORTW-1:0] m_port;
  logic [255:0]     m_data;
  logic             m_ovf;
  logic             m_unf;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpmc11_rd_tag_dispatch dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_port  (cmd_port),
    .cmd_rdy   (cmd_rdy),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rdy       (rdy),
    .fifo_port (fifo_port),
    .dat_o     (dat_o),
    .count     (count),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic popped);
    beat_t e;
    if (popped) begin
      e = exp_q.pop_front();
      m_port = e.port;
      m_data = e.data;
    end
    chk("rdy", rdy, popped);
    chk("fifo_port", fifo_port, m_port);
    chk("dat_o", dat_o, m_data);
    chk("count", count, tag_q.size());
    chk("cmd_rdy", cmd_rdy, tag_q.size() != DEPTH);
    chk("ovf_err", ovf_err, m_ovf);
    chk("unf_err", unf_err, m_unf);
  endtask

  task automatic step(input logic cv, input logic [PORTW-1:0] cp,
                      input logic rv);
    logic [255:0] d;
    logic full, empty, pop, push;
    beat_t b;
    d = {8{$urandom}};
    cmd_valid = cv;
    cmd_port  = cp;
    rd_valid  = rv;
    rd_data   = d;
    full  = (tag_q.size() == DEPTH);
    empty = (tag_q.size() == 0);
    pop   = rv && !empty;
    push  = cv && (!full || pop);
    if (pop) begin
      b.port = tag_q.pop_front();
      b.data = d;
      exp_q.push_back(b);
    end
    if (push) tag_q.push_back(cp);
    if (cv && !push) m_ovf = 1'b1;
    if (rv && empty) m_unf = 1'b1;
    @(posedge clk);
    #1;
    check_all(pop);
  endtask

  task automatic do_reset(input int n);
    cmd_valid = 1'b0;
    rd_valid  = 1'b0;
    rstn      = 1'b0;
    tag_q.delete();
    exp_q.delete();
    m_port = '0;
    m_data = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_all(1'b0);
    end
    rstn = 1'b1;
  endtask

  initial begin
    cmd_port = '0;
    rd_data  = '0;
    #1;
    do_reset(2);

    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, PORTW'(i), 1'b0);
    step(1'b1, PORTW'(16), 1'b1);
    step(1'b1, 4'd9, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    step(1'b1, 4'd5, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, PORTW'(i + 2), 1'b0);
    do_reset(1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
